// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0-side TLB management controller:
// instruction encodings, CP0 register map, FSM states and the entry payload.
package tlb_pkg;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } tlb_state_e;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    localparam logic [31:0] PROBE_INDEX = 32'hFFFF_FFFF;
    localparam int unsigned INDEX_P_BIT = 31;

    // EntryHi/EntryLo0/EntryLo1 travel together to and from the TLB
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } tlb_entry_t;

    function automatic logic op_is_write(input tlb_op_e o);
        return (o == OP_TLBWI) || (o == OP_TLBWR);
    endfunction

endpackage

// File: rtl/tlb_random_cnt.sv
// CP0 Random register: free-running down-counter that wraps from Wired
// back to the top entry, and restarts at the top on any Wired write.
module tlb_random_cnt #(
    parameter int unsigned TLB_ENTRIES = 16,
    parameter int unsigned IW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wired_we,
    input  logic [IW-1:0] wired,
    output logic [IW-1:0] random_val
);

    localparam logic [IW-1:0] TOP = IW'(TLB_ENTRIES - 1);

    // Decrement each cycle; reload the top entry on wrap, Wired write or a full wired set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_val <= TOP;
        end else if (wired_we || (wired >= TOP) || (random_val <= wired)) begin
            random_val <= TOP;
        end else begin
            random_val <= random_val - IW'(1);
        end
    end

endmodule

// File: rtl/tlb_cp0_ctrl.sv
// CP0-side initiator of the TLB management port. Holds Index/Random/Wired/
// EntryHi/EntryLo0/EntryLo1 and turns TLBR/TLBWI/TLBWR/TLBP into single-cycle
// TLB strobes, capturing read and probe responses.
// Optional: TLB_CTRL_TIMEOUT_EN adds a response watchdog that raises op_err.
module tlb_cp0_ctrl #(
    parameter int unsigned TLB_ENTRIES = 16,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op,
    output logic        op_busy,
    output logic        op_done,
    output logic        op_err,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        tlb_we,
    output logic        tlb_rd,
    output logic [31:0] tlb_index,
    output logic [31:0] tlb_entry_hi,
    output logic [31:0] tlb_entry_lo0,
    output logic [31:0] tlb_entry_lo1,
    input  logic        tlb_w_index,
    input  logic        tlb_w_content,
    input  logic [31:0] tlb_index_out,
    input  logic [31:0] tlb_entry_hi_out,
    input  logic [31:0] tlb_entry_lo0_out,
    input  logic [31:0] tlb_entry_lo1_out
);
    import tlb_pkg::*;

    localparam int unsigned IW = $clog2(TLB_ENTRIES);

    tlb_state_e    state;
    tlb_op_e       op_q;
    logic          index_p;
    logic [IW-1:0] index_val;
    logic [IW-1:0] wired;
    logic [IW-1:0] random_val;
    tlb_entry_t    entry;

    logic mtc0_ok;
    logic wired_we;
    logic cap_read;
    logic cap_probe;
    logic unused_bits;

    // mtc0 is only honoured while no TLB operation is in flight
    assign mtc0_ok   = cp0_we && !op_busy;
    assign wired_we  = mtc0_ok && (cp0_waddr == CP0_WIRED);
    assign cap_read  = (state == ST_WAIT) && (op_q == OP_TLBR) && tlb_w_content;
    assign cap_probe = (state == ST_WAIT) && (op_q == OP_TLBP) && tlb_w_index;

    assign unused_bits = ^tlb_index_out[30:IW];

`ifdef TLB_CTRL_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    assign timeout_hit = (state == ST_WAIT) && !cap_read && !cap_probe
                         && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYC;
    assign op_err = 1'b0;
`endif

    assign tlb_entry_hi  = entry.hi;
    assign tlb_entry_lo0 = entry.lo0;
    assign tlb_entry_lo1 = entry.lo1;

    tlb_random_cnt #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .IW          (IW)
    ) u_random (
        .clk        (clk),
        .rst        (rst),
        .wired_we   (wired_we),
        .wired      (wired),
        .random_val (random_val)
    );

    // CP0 register file: mtc0 writes plus TLB response captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_p   <= 1'b0;
            index_val <= '0;
            wired     <= '0;
            entry     <= '0;
        end else begin
            if (mtc0_ok) begin
                case (cp0_waddr)
                    CP0_INDEX: begin
                        index_val <= cp0_wdata[IW-1:0];
                        index_p   <= 1'b0;
                    end
                    CP0_ENTRYLO0: entry.lo0 <= cp0_wdata;
                    CP0_ENTRYLO1: entry.lo1 <= cp0_wdata;
                    CP0_WIRED:    wired     <= cp0_wdata[IW-1:0];
                    CP0_ENTRYHI:  entry.hi  <= cp0_wdata;
                    default: ;
                endcase
            end
            if (cap_read) begin
                entry.hi  <= tlb_entry_hi_out;
                entry.lo0 <= tlb_entry_lo0_out;
                entry.lo1 <= tlb_entry_lo1_out;
            end
            if (cap_probe) begin
                index_p   <= tlb_index_out[INDEX_P_BIT];
                index_val <= tlb_index_out[IW-1:0];
            end
`ifdef TLB_CTRL_TIMEOUT_EN
            if (timeout_hit && (op_q == OP_TLBP)) begin
                index_p <= 1'b1;
            end
`endif
        end
    end

    // Operation sequencer with registered strobes and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_TLBR;
            op_busy   <= 1'b0;
            op_done   <= 1'b0;
            tlb_we    <= 1'b0;
            tlb_rd    <= 1'b0;
            tlb_index <= '0;
`ifdef TLB_CTRL_TIMEOUT_EN
            op_err    <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            tlb_we  <= 1'b0;
            tlb_rd  <= 1'b0;
            op_done <= 1'b0;
`ifdef TLB_CTRL_TIMEOUT_EN
            op_err  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_q    <= tlb_op_e'(op);
                        op_busy <= 1'b1;
                        state   <= ST_ISSUE;
                        case (tlb_op_e'(op))
                            OP_TLBR: begin
                                tlb_rd    <= 1'b1;
                                tlb_index <= 32'(index_val);
                            end
                            OP_TLBWI: begin
                                tlb_we    <= 1'b1;
                                tlb_index <= 32'(index_val);
                            end
                            OP_TLBWR: begin
                                tlb_we    <= 1'b1;
                                tlb_index <= 32'(random_val);
                            end
                            default: begin
                                tlb_rd    <= 1'b1;
                                tlb_index <= PROBE_INDEX;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (op_is_write(op_q)) begin
                        state   <= ST_DONE;
                        op_done <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
`ifdef TLB_CTRL_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (cap_read || cap_probe) begin
                        state   <= ST_DONE;
                        op_done <= 1'b1;
                    end
`ifdef TLB_CTRL_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state   <= ST_DONE;
                        op_done <= 1'b1;
                        op_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    op_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // mfc0 read mux; Index carries the probe-failure flag in its top bit
    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_INDEX: begin
                cp0_rdata              = 32'(index_val);
                cp0_rdata[INDEX_P_BIT] = index_p;
            end
            CP0_RANDOM:   cp0_rdata = 32'(random_val);
            CP0_ENTRYLO0: cp0_rdata = entry.lo0;
            CP0_ENTRYLO1: cp0_rdata = entry.lo1;
            CP0_WIRED:    cp0_rdata = 32'(wired);
            CP0_ENTRYHI:  cp0_rdata = entry.hi;
            default:      cp0_rdata = '0;
        endcase
    end

endmodule
